// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Load/store controller between the CPU datapath and a 4096x8 big-endian,
// byte-addressable memory that only writes whole 32-bit words. It takes one
// byte/halfword/word request at a time and returns zero- or sign-extended load
// data. Sub-word stores are done as read-modify-write.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. The response is a
// single-cycle rsp_valid pulse with no backpressure. rsp_rdata and rsp_err
// hold until the next response, and rsp_err is cleared on the next acceptance.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_wr, req_size, req_signed, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err                       response
//   mem_cs, mem_rd, mem_wr, mem_addr, mem_din           memory pins (out)
//   mem_dout                                            memory read data (in)
// ---------------------------------------------------------------------------
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_cs,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        accept;
    logic        req_err;

    // Big-endian lane extraction: byte offset o lives in bits [31-8o -: 8],
    // halfword at offset 0 in [31:16], at offset 2 in [15:0].
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Replace only the addressed lane of the captured word; a word store
    // passes the store data straight through.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        case (size)
            SZ_BYTE: begin
                case (off)
                    2'd0:    r[31:24] = wd[7:0];
                    2'd1:    r[23:16] = wd[7:0];
                    2'd2:    r[15:8]  = wd[7:0];
                    default: r[7:0]   = wd[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) r[15:0]  = wd[15:0];
                else        r[31:16] = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    assign accept = req_valid && (state_q == ST_IDLE);

    // Illegal size or misalignment; such requests never touch memory.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)                                state_d = ST_RSP;
                    else if (req_wr && (req_size == SZ_WORD))   state_d = ST_WR;
                    else                                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = wr_q ? ST_WR : ST_RSP;
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // Memory pins decode only from registered state and latched fields, so
    // an asynchronous reset in RD/WR drops mem_cs at once.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_cs    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'h0;
        mem_din   = 32'h0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_RD: begin
                mem_cs   = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
            end
            ST_WR: begin
                mem_cs   = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
                mem_din  = store_merge(word_q, addr_q[1:0], size_q, wdata_q);
            end
            ST_RSP:  rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // ---------------- datapath next values ----------------
    always_comb begin
        wr_d        = wr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (accept) begin
            wr_d      = req_wr;
            size_d    = req_size;
            signed_d  = req_signed;
            addr_d    = req_addr;
            wdata_d   = req_wdata;
            rsp_err_d = req_err;
            // Errors go straight to RSP, so their (zero) result is set here.
            if (req_err) rsp_rdata_d = 32'h0;
        end

        if (state_q == ST_RD) begin
            word_d = mem_dout;
            if (!wr_q) rsp_rdata_d = load_extract(mem_dout, addr_q[1:0], size_q, signed_q);
        end

        // Stores always respond from WR with a zero result.
        if (state_q == ST_WR) rsp_rdata_d = 32'h0;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            word_q      <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. A word-array memory model answers the
// controller's pins; expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_cs;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    mem_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_cs     (mem_cs),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // ---------------- memory model (1024 words = 4096 bytes) ----------------
    logic [31:0] mem [0:1023];
    // The idle read bus is modelled as zero.
    assign mem_dout = (mem_cs && mem_rd) ? mem[mem_addr[11:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_cs && mem_wr) mem[mem_addr[11:2]] <= mem_din;
    end

    // ---------------- scoreboard ----------------
    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata = 32'h0;
    logic        last_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, " rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, " mem_ctl"},   32'({mem_cs, mem_rd, mem_wr}), 32'd0);
        chk({tag, " mem_addr"},  mem_addr, 32'h0);
        chk({tag, " mem_din"},   mem_din, 32'h0);
    endtask

    // ---------------- driver: one request, checked end to end ----------------
    task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [31:0] exp_din);
        int lat;
        int rd_at;
        int wr_at;
        int cs_cycles;
        bit got;
        rd_at = 0;
        wr_at = 0;
        cs_cycles = 0;
        got = 1'b0;

        @(negedge clk);
        chk({tag, " idle ready"},     32'(req_ready), 32'd1);
        chk({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " held rdata"},     rsp_rdata, last_rdata);
        chk({tag, " held err"},       32'(rsp_err), 32'(last_err));
        req_wr     = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;

        @(negedge clk);   // acceptance edge has passed
        req_valid  = 1'b0;
        // Scramble the fields: memory pins must not follow them.
        req_wr     = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom();
        req_wdata  = $urandom();
        if (exp_lat > 1) chk({tag, " err cleared on accept"}, 32'(rsp_err), 32'd0);

        lat = 1;
        while (!got && lat <= 6) begin
            if (mem_cs) cs_cycles++;
            if (mem_rd) begin
                rd_at = lat;
                chk({tag, " rd addr"}, mem_addr, {addr[31:2], 2'b00});
            end
            if (mem_wr) begin
                wr_at = lat;
                chk({tag, " wr addr"}, mem_addr, {addr[31:2], 2'b00});
                chk({tag, " wr din"},  mem_din, exp_din);
            end
            if (mem_rd && mem_wr) chk({tag, " rd&wr"}, 32'd1, 32'd0);
            if (rsp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, " responded"}, 32'(got), 32'd1);
        chk({tag, " latency"},   32'(lat), 32'(exp_lat));
        chk({tag, " rdata"},     rsp_rdata, exp_rdata);
        chk({tag, " err"},       32'(rsp_err), 32'(exp_err));
        chk({tag, " cs cycles"}, 32'(cs_cycles), 32'(exp_lat - 1));
        if (exp_lat == 3) begin
            chk({tag, " rd cycle"}, 32'(rd_at), 32'd1);
            chk({tag, " wr cycle"}, 32'(wr_at), 32'd2);
        end
        last_rdata = exp_rdata;
        last_err   = exp_err;
    endtask

    // ---------------- directed sequence ----------------
    int acc [3];
    int idx;
    int cyc;

    initial begin
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        mem[8]  <= 32'h12F45678;   // 0x020
        mem[12] <= 32'h11223344;   // 0x030

        // Reset state
        #1 reset = 1'b1;
        @(negedge clk);
        chk_outputs_reset("reset");
        reset = 1'b0;

        // Word store then word load
        do_req("sw 0x010", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 32'hDEADBEEF);
        chk("mem 0x010", mem[4], 32'hDEADBEEF);
        do_req("lw 0x010", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 32'h0);

        // Byte / halfword loads from 0x12F45678
        do_req("lb 0x021", 1'b0, 2'b00, 1'b1, 32'h021, 32'h0, 2, 32'hFFFFFFF4, 1'b0, 32'h0);
        do_req("lbu 0x021", 1'b0, 2'b00, 1'b0, 32'h021, 32'h0, 2, 32'h000000F4, 1'b0, 32'h0);
        do_req("lb 0x023", 1'b0, 2'b00, 1'b1, 32'h023, 32'h0, 2, 32'h00000078, 1'b0, 32'h0);
        do_req("lh 0x020", 1'b0, 2'b01, 1'b1, 32'h020, 32'h0, 2, 32'h000012F4, 1'b0, 32'h0);
        do_req("lh 0x022", 1'b0, 2'b01, 1'b1, 32'h022, 32'h0, 2, 32'h00005678, 1'b0, 32'h0);

        // Error requests (previous rdata is nonzero, must become 0)
        do_req("err half 0x041", 1'b0, 2'b01, 1'b0, 32'h041, 32'h0, 1, 32'h0, 1'b1, 32'h0);
        do_req("err word 0x042", 1'b1, 2'b10, 1'b0, 32'h042, 32'h55, 1, 32'h0, 1'b1, 32'h0);
        do_req("err size 11",    1'b0, 2'b11, 1'b1, 32'h040, 32'h0, 1, 32'h0, 1'b1, 32'h0);

        // Sub-word stores (read-modify-write)
        do_req("sb 0x032", 1'b1, 2'b00, 1'b1, 32'h032, 32'h000000AB, 3, 32'h0, 1'b0, 32'h1122AB44);
        chk("mem after sb", mem[12], 32'h1122AB44);
        do_req("sh 0x030", 1'b1, 2'b01, 1'b0, 32'h030, 32'h0000CDEF, 3, 32'h0, 1'b0, 32'hCDEFAB44);
        chk("mem after sh", mem[12], 32'hCDEFAB44);

        // Reset during WR of a byte store to 0x050
        @(negedge clk);
        req_wr = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h050; req_wdata = 32'h0000005A; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midwr in RD", 32'(mem_rd), 32'd1);
        @(negedge clk);
        chk("midwr in WR", 32'(mem_wr), 32'd1);
        #1 reset = 1'b1;
        #1 chk_outputs_reset("midwr async");
        @(negedge clk);
        chk("midwr mem untouched", mem[20], 32'h0);
        chk_outputs_reset("midwr held");
        reset = 1'b0;
        last_rdata = 32'h0;
        last_err   = 1'b0;
        do_req("sb 0x050 after rst", 1'b1, 2'b00, 1'b0, 32'h050, 32'h0000005A, 3, 32'h0, 1'b0, 32'h5A000000);
        chk("mem 0x050", mem[20], 32'h5A000000);

        // Back-to-back with req_valid held high: lw 0x010, sw 0x060, lw 0x060
        exp_q = {32'hDEADBEEF, 32'h0, 32'h12345678};
        idx = 0;
        cyc = 0;
        while (cyc < 40 && (idx < 3 || exp_q.size() > 0)) begin
            @(negedge clk);
            cyc++;
            if (mem_rd && mem_wr) chk("b2b rd&wr", 32'd1, 32'd0);
            if (rsp_valid) begin
                if (exp_q.size() > 0) chk("b2b rdata", rsp_rdata, exp_q.pop_front());
                else chk("b2b extra rsp", 32'(exp_q.size()), 32'd1);
            end
            if (idx < 3) begin
                req_valid  = 1'b1;
                req_signed = 1'b0;
                req_wr     = (idx == 1);
                req_size   = 2'b10;
                req_addr   = (idx == 0) ? 32'h010 : 32'h060;
                req_wdata  = (idx == 1) ? 32'h12345678 : 32'h0;
                if (req_ready) begin
                    acc[idx] = cyc;
                    idx++;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("b2b accepted", 32'(idx), 32'd3);
        chk("b2b responses left", 32'(exp_q.size()), 32'd0);
        chk("b2b spacing 0-1", 32'(acc[1] - acc[0]), 32'd3);
        chk("b2b spacing 1-2", 32'(acc[2] - acc[1]), 32'd3);
        chk("b2b mem 0x060", mem[24], 32'h12345678);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
